i2c_target_regfile: RTL and testbench

//  I2C target (responder) that answers the register-programming transactions our I2C

---
 rtl/i2c_target_regfile.sv | 187 ++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file: pointer byte, then burst writes or reads.
// Pins are synchronised and edge-detected; SDA is only ever pulled low.
module i2c_target_regfile #(
  parameter logic [6:0] DEV_ADDR    = 7'h39,
  parameter int         NREGS       = 256,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic       reg_wr_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       busy_o,
  input  logic [7:0] dbg_addr_i,
  output logic [7:0] dbg_data_o
);

  localparam int          AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int unsigned NREGS_U = NREGS;

  typedef enum logic [3:0] {
    IDLE, ADDR, SKIP, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, MACK
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_prev;
  logic                   sda_prev;
  logic [3:0]             bit_cnt;
  logic [7:0]             shifter;
  logic [7:0]             pointer;
  logic                   rw;
  logic [7:0]             regs [NREGS];

  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0] next_byte, ptr_inc, ptr_load, cur_reg;

  // Synchronisers idle high so that leaving reset never fakes a START or STOP.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_prev <= scl_sync[SYNC_STAGES-1];
      sda_prev <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s & scl_prev;
  assign start_ev  = scl_s & scl_prev & sda_prev & ~sda_s;
  assign stop_ev   = scl_s & scl_prev & ~sda_prev & sda_s;

  assign next_byte = {shifter[6:0], sda_s};
  assign ptr_inc   = ({24'd0, pointer} == NREGS_U - 1) ? 8'd0 : pointer + 8'd1;
  assign ptr_load  = 8'({24'd0, next_byte} % NREGS_U);
  assign cur_reg   = regs[pointer[AW-1:0]];

  assign busy_o     = (state != IDLE) && (state != SKIP);
  assign dbg_data_o = ({24'd0, dbg_addr_i} < NREGS_U) ? regs[dbg_addr_i[AW-1:0]] : 8'h00;

  // START/STOP override every state; otherwise bits are shifted on SCL rise and
  // SDA is only moved on the cycle an SCL fall is seen.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      bit_cnt     <= 4'd0;
      shifter     <= 8'h00;
      pointer     <= 8'h00;
      rw          <= 1'b0;
      sda_oe_o    <= 1'b0;
      reg_wr_o    <= 1'b0;
      reg_addr_o  <= 8'h00;
      reg_wdata_o <= 8'h00;
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
    end else begin
      reg_wr_o <= 1'b0;
      if (start_ev) begin
        state    <= ADDR;
        bit_cnt  <= 4'd0;
        sda_oe_o <= 1'b0;
      end else if (stop_ev) begin
        state    <= IDLE;
        sda_oe_o <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shifter <= next_byte;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (shifter[7:1] == DEV_ADDR) begin
                state    <= ADDR_ACK;
                rw       <= shifter[0];
                sda_oe_o <= 1'b1;
              end else begin
                state <= SKIP;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 4'd0;
              if (rw) begin
                shifter  <= cur_reg;
                sda_oe_o <= ~cur_reg[7];
                state    <= RDATA;
              end else begin
                sda_oe_o <= 1'b0;
                state    <= PTR;
              end
            end
          end
          PTR: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shifter <= next_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) pointer <= ptr_load;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              state    <= PTR_ACK;
              sda_oe_o <= 1'b1;
            end
          end
          WDATA: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shifter <= next_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                regs[pointer[AW-1:0]] <= next_byte;
                reg_wr_o              <= 1'b1;
                reg_addr_o            <= pointer;
                reg_wdata_o           <= next_byte;
                pointer               <= ptr_inc;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              state    <= WDATA_ACK;
              sda_oe_o <= 1'b1;
            end
          end
          PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              state    <= WDATA;
              bit_cnt  <= 4'd0;
              sda_oe_o <= 1'b0;
            end
          end
          RDATA: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_oe_o <= 1'b0;
              pointer  <= ptr_inc;
              state    <= MACK;
            end else if (scl_fall && bit_cnt != 4'd0) begin
              shifter  <= {shifter[6:0], 1'b0};
              sda_oe_o <= ~shifter[6];
            end
          end
          MACK: begin
            // A falling edge here can only follow an ACKed ninth clock; NACK left already.
            if (scl_rise && sda_s) begin
              state <= SKIP;
            end else if (scl_fall) begin
              shifter  <= cur_reg;
              sda_oe_o <= ~cur_reg[7];
              bit_cnt  <= 4'd0;
              state    <= RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench: bit-bangs an I2C initiator against the target and checks acks,
// read data, write strobes and the debug port against hand-computed values.
module tb_i2c_target_regfile;

  localparam int Q = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_low = 1'b0;
  logic       sda_line;
  logic       sda_oe;
  logic       reg_wr;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       busy;
  logic [7:0] dbg_addr = 8'h00;
  logic [7:0] dbg_data;

  int   errors = 0;
  int   checks = 0;
  int   wr_count = 0;
  logic [7:0] last_wr_addr = 8'h00;
  logic [7:0] last_wr_data = 8'h00;
  logic oe_seen = 1'b0;

  assign sda_line = ~(sda_low | sda_oe);

  i2c_target_regfile dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .scl_i      (scl_m),
    .sda_i      (sda_line),
    .sda_oe_o   (sda_oe),
    .reg_wr_o   (reg_wr),
    .reg_addr_o (reg_addr),
    .reg_wdata_o(reg_wdata),
    .busy_o     (busy),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reg_wr) begin
      wr_count     = wr_count + 1;
      last_wr_addr = reg_addr;
      last_wr_data = reg_wdata;
    end
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic i2c_start();
    sda_low = 1'b0; tick(Q);
    scl_m   = 1'b1; tick(Q);
    sda_low = 1'b1; tick(Q);
    scl_m   = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1; tick(Q);
    scl_m   = 1'b1; tick(Q);
    sda_low = 1'b0; tick(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_low = ~b; tick(Q);
    scl_m   = 1'b1; tick(2 * Q);
    scl_m   = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] data, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(data[i]);
    sda_low = 1'b0; tick(Q);
    scl_m   = 1'b1; tick(Q);
    ack     = sda_line;
    tick(Q);
    scl_m   = 1'b0; tick(Q);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] data);
    for (int i = 7; i >= 0; i--) begin
      sda_low = 1'b0; tick(Q);
      scl_m   = 1'b1; tick(Q);
      data[i] = sda_line;
      tick(Q);
      scl_m   = 1'b0; tick(Q);
    end
    sda_low = master_ack; tick(Q);
    scl_m   = 1'b1; tick(2 * Q);
    scl_m   = 1'b0; tick(Q);
    sda_low = 1'b0;
  endtask

  task automatic peek(input logic [7:0] idx, input logic [7:0] expected, input string tag);
    dbg_addr = idx;
    #1;
    check_output(tag, dbg_data, expected);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rdata;
    int         wr_base;

    // Reset state
    tick(3);
    check_output("reset_oe", sda_oe, 1'b0);
    check_output("reset_wr", reg_wr, 1'b0);
    check_output("reset_addr", reg_addr, 8'h00);
    check_output("reset_wdata", reg_wdata, 8'h00);
    check_output("reset_busy", busy, 1'b0);
    rst = 1'b0;
    tick(4);
    peek(8'h41, 8'h00, "reset_reg41");

    // Single write 0x41 <= 0x10
    i2c_start();
    write_byte(8'h72, ack); check_output("t1_ack_addr", ack, 1'b0);
    check_output("t1_busy", busy, 1'b1);
    write_byte(8'h41, ack); check_output("t1_ack_ptr", ack, 1'b0);
    write_byte(8'h10, ack); check_output("t1_ack_data", ack, 1'b0);
    i2c_stop();
    tick(4);
    check_output("t1_wr_count", wr_count, 1);
    check_output("t1_last_addr", last_wr_addr, 8'h41);
    check_output("t1_last_data", last_wr_data, 8'h10);
    check_output("t1_reg_addr", reg_addr, 8'h41);
    check_output("t1_reg_wdata", reg_wdata, 8'h10);
    check_output("t1_busy_idle", busy, 1'b0);
    peek(8'h41, 8'h10, "t1_reg41");

    // Seed reg 0x01 so the pointer left by the burst can be observed by a read
    i2c_start();
    write_byte(8'h72, ack);
    write_byte(8'h01, ack);
    write_byte(8'h5A, ack); check_output("seed_ack", ack, 1'b0);
    i2c_stop();
    tick(4);

    // Burst wrapping 0xFE -> 0xFF -> 0x00
    wr_base = wr_count;
    i2c_start();
    write_byte(8'h72, ack);
    write_byte(8'hFE, ack); check_output("t2_ack_ptr", ack, 1'b0);
    write_byte(8'hAA, ack); check_output("t2_ack_aa", ack, 1'b0);
    write_byte(8'hBB, ack); check_output("t2_ack_bb", ack, 1'b0);
    write_byte(8'hCC, ack); check_output("t2_ack_cc", ack, 1'b0);
    i2c_stop();
    tick(4);
    check_output("t2_strobes", wr_count - wr_base, 3);
    peek(8'hFE, 8'hAA, "t2_regFE");
    peek(8'hFF, 8'hBB, "t2_regFF");
    peek(8'h00, 8'hCC, "t2_reg00");
    i2c_start();
    write_byte(8'h73, ack); check_output("t2_rd_ack", ack, 1'b0);
    read_byte(1'b0, rdata);
    check_output("t2_ptr_read", rdata, 8'h5A);
    i2c_stop();
    tick(4);

    // Pointer write, repeated START, two-byte read
    i2c_start();
    write_byte(8'h72, ack);
    write_byte(8'h41, ack); check_output("t3_ack_ptr", ack, 1'b0);
    i2c_start();
    write_byte(8'h73, ack); check_output("t3_ack_rd", ack, 1'b0);
    read_byte(1'b1, rdata);
    check_output("t3_byte0", rdata, 8'h10);
    read_byte(1'b0, rdata);
    check_output("t3_byte1", rdata, 8'h00);
    oe_seen = 1'b0;
    i2c_stop();
    tick(4);
    check_output("t3_oe_after_nack", oe_seen, 1'b0);
    check_output("t3_busy", busy, 1'b0);

    // Foreign address 0x90 is ignored
    wr_base = wr_count;
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'h90, ack); check_output("t4_nack_addr", ack, 1'b1);
    check_output("t4_busy", busy, 1'b0);
    write_byte(8'h12, ack); check_output("t4_nack_data", ack, 1'b1);
    i2c_stop();
    tick(4);
    check_output("t4_oe_seen", oe_seen, 1'b0);
    check_output("t4_no_strobe", wr_count - wr_base, 0);

    // Reset while acknowledging a data byte
    i2c_start();
    write_byte(8'h72, ack);
    write_byte(8'h41, ack);
    for (int i = 7; i >= 0; i--) send_bit(1'((8'h55 >> i) & 8'h01));
    sda_low = 1'b0; tick(Q);
    check_output("t5_oe_acking", sda_oe, 1'b1);
    rst = 1'b1;
    #1;
    check_output("t5_oe_async", sda_oe, 1'b0);
    tick(3);
    peek(8'h41, 8'h00, "t5_reg41_cleared");
    peek(8'hFE, 8'h00, "t5_regFE_cleared");
    check_output("t5_busy", busy, 1'b0);
    rst = 1'b0;
    tick(4);
    i2c_start();
    write_byte(8'h72, ack); check_output("t5_ack_addr", ack, 1'b0);
    write_byte(8'h41, ack); check_output("t5_ack_ptr", ack, 1'b0);
    write_byte(8'h66, ack); check_output("t5_ack_data", ack, 1'b0);
    i2c_stop();
    tick(4);
    peek(8'h41, 8'h66, "t5_reg41");

    // STOP in the middle of a data byte
    wr_base = wr_count;
    i2c_start();
    write_byte(8'h72, ack);
    write_byte(8'h30, ack); check_output("t6_ack_ptr", ack, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    i2c_stop();
    tick(4);
    check_output("t6_no_strobe", wr_count - wr_base, 0);
    check_output("t6_busy", busy, 1'b0);
    check_output("t6_oe", sda_oe, 1'b0);
    peek(8'h30, 8'h00, "t6_reg30");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
